mem_writeback_unit: RTL and testbench

MEM_WRITEBACK_UNIT -- requirements
Module: mem_writeback_unit

---
 rtl/mem_writeback_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_writeback_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_writeback_unit.sv
// ---------------------------------------------------------------------------
// mem_writeback_unit
//
// Final pipeline stage. It retires register writes for non-memory instructions
// one cycle after they arrive. Memory reads are turned into a held
// request/acknowledge transaction. The read data, or a byte of it, is then
// written back to the register file.
//
// A read that is never acknowledged is aborted after TIMEOUT cycles. The abort
// raises a one-cycle mem_err and produces no register write.
//
// While stall is high the upstream stage holds every *_in signal stable.
// alu_result_in is therefore still valid when a load completes.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   mem_read_in         current instruction is a memory read
//   reg_wr_en_1_in      register write-port 1 enable
//   reg_wr_en_2_in      register write-port 2 enable
//   buff_ctrl_in [2:0]  writeback data-source / format select
//   reg_wr_sel_in [3:0] destination register index
//   mem_addr_in [15:0]  memory address, also a pass-through writeback value
//   alu_result_in[15:0] ALU result for non-memory writeback
//   mem_req             registered read request (held while waiting)
//   mem_addr [15:0]     registered read address, stable while mem_req=1
//   mem_ack             read-data-valid strobe (ignored outside WAIT)
//   mem_rdata [15:0]    read data, valid with mem_ack
//   stall               combinational back-pressure to upstream
//   rf_wr_en_1/2        registered register-file write enables
//   rf_wr_sel [3:0]     registered destination index
//   rf_wr_data [15:0]   registered writeback data
//   mem_err             registered one-cycle pulse on read timeout
// ---------------------------------------------------------------------------
module mem_writeback_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        reg_wr_en_1_in,
    input  logic        reg_wr_en_2_in,
    input  logic [2:0]  buff_ctrl_in,
    input  logic [3:0]  reg_wr_sel_in,
    input  logic [15:0] mem_addr_in,
    input  logic [15:0] alu_result_in,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        stall,
    output logic        rf_wr_en_1,
    output logic        rf_wr_en_2,
    output logic [3:0]  rf_wr_sel,
    output logic [15:0] rf_wr_data,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Counter value seen in the last WAIT cycle before the read is abandoned.
    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic        lat_en_1_reg;
    logic        lat_en_2_reg;
    logic [3:0]  lat_sel_reg;
    logic [2:0]  lat_bc_reg;

    // Writeback formatting. mem_src is the memory data for a load. For a
    // non-load it is the ALU result, so byte formats slice the ALU value.
    function automatic logic [15:0] format_data(
        input logic [2:0]  bc,
        input logic [15:0] mem_src,
        input logic [15:0] alu,
        input logic [15:0] addr
    );
        logic [15:0] res;
        case (bc)
            3'b001:  res = mem_src;
            3'b010:  res = {8'h00, mem_src[7:0]};
            3'b011:  res = {8'h00, mem_src[15:8]};
            3'b100:  res = addr;
            default: res = alu;
        endcase
        return res;
    endfunction

    // The instruction is consumed on a clock edge where stall is low. In WB
    // this lets the held load retire while the new inputs are disregarded.
    always_comb begin
        stall = ((state_reg == S_IDLE) && mem_read_in) || (state_reg == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            lat_en_1_reg <= 1'b0;
            lat_en_2_reg <= 1'b0;
            lat_sel_reg  <= 4'd0;
            lat_bc_reg   <= 3'd0;
            mem_req      <= 1'b0;
            mem_addr     <= 16'd0;
            rf_wr_en_1   <= 1'b0;
            rf_wr_en_2   <= 1'b0;
            rf_wr_sel    <= 4'd0;
            rf_wr_data   <= 16'd0;
            mem_err      <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (mem_read_in) begin
                        lat_en_1_reg <= reg_wr_en_1_in;
                        lat_en_2_reg <= reg_wr_en_2_in;
                        lat_sel_reg  <= reg_wr_sel_in;
                        lat_bc_reg   <= buff_ctrl_in;
                        mem_addr     <= mem_addr_in;
                        mem_req      <= 1'b1;
                        wait_cnt_reg <= 4'd0;
                        rf_wr_en_1   <= 1'b0;
                        rf_wr_en_2   <= 1'b0;
                        state_reg    <= S_WAIT;
                    end else begin
                        // Select/data update even with both enables low; the
                        // register file only acts on the enables.
                        rf_wr_en_1 <= reg_wr_en_1_in;
                        rf_wr_en_2 <= reg_wr_en_2_in;
                        rf_wr_sel  <= reg_wr_sel_in;
                        rf_wr_data <= format_data(buff_ctrl_in, alu_result_in,
                                                  alu_result_in, mem_addr_in);
                    end
                end
                S_WAIT: begin
                    // The ack is tested first, so it wins over a coincident
                    // timeout.
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        rf_wr_en_1 <= lat_en_1_reg;
                        rf_wr_en_2 <= lat_en_2_reg;
                        rf_wr_sel  <= lat_sel_reg;
                        rf_wr_data <= format_data(lat_bc_reg, mem_rdata,
                                                  alu_result_in, mem_addr);
                        state_reg  <= S_WB;
                    end else if (wait_cnt_reg == LAST_WAIT) begin
                        mem_req    <= 1'b0;
                        mem_err    <= 1'b1;
                        rf_wr_en_1 <= 1'b0;
                        rf_wr_en_2 <= 1'b0;
                        state_reg  <= S_WB;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                        rf_wr_en_1   <= 1'b0;
                        rf_wr_en_2   <= 1'b0;
                    end
                end
                S_WB: begin
                    rf_wr_en_1 <= 1'b0;
                    rf_wr_en_2 <= 1'b0;
                    state_reg  <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_writeback_unit.sv
// ---------------------------------------------------------------------------
// Testbench for mem_writeback_unit.
//
// The bench behaves as the upstream stage. It presents one instruction at a
// time and holds it while stall is high. The instruction advances on the edge
// where stall is low.
//
// Expected outputs are a per-instruction description of what the register
// file and memory port must show on each cycle. That description is derived
// from the instruction fields and the chosen ack delay. Outputs are sampled on
// the falling edge. Inputs are driven 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_writeback_unit;

    localparam int TO = 15;

    logic        clk;
    logic        reset;
    logic        mem_read_in;
    logic        reg_wr_en_1_in;
    logic        reg_wr_en_2_in;
    logic [2:0]  buff_ctrl_in;
    logic [3:0]  reg_wr_sel_in;
    logic [15:0] mem_addr_in;
    logic [15:0] alu_result_in;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        rf_wr_en_1;
    logic        rf_wr_en_2;
    logic [3:0]  rf_wr_sel;
    logic [15:0] rf_wr_data;
    logic        mem_err;

    mem_writeback_unit #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read_in    (mem_read_in),
        .reg_wr_en_1_in (reg_wr_en_1_in),
        .reg_wr_en_2_in (reg_wr_en_2_in),
        .buff_ctrl_in   (buff_ctrl_in),
        .reg_wr_sel_in  (reg_wr_sel_in),
        .mem_addr_in    (mem_addr_in),
        .alu_result_in  (alu_result_in),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .stall          (stall),
        .rf_wr_en_1     (rf_wr_en_1),
        .rf_wr_en_2     (rf_wr_en_2),
        .rf_wr_sel      (rf_wr_sel),
        .rf_wr_data     (rf_wr_data),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected output state for the current cycle.
    logic        exp_en_1, exp_en_2, exp_req, exp_err, exp_wb_known;
    logic [3:0]  exp_sel;
    logic [15:0] exp_data, exp_addr;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Writeback value for an instruction with the given format. A load uses
    // the memory word. A non-load uses the ALU result as the byte source.
    function automatic logic [15:0] expected_value(input logic [2:0] bc, input bit is_load,
                                                   input logic [15:0] rdata, input logic [15:0] alu,
                                                   input logic [15:0] addr);
        logic [15:0] src;
        src = is_load ? rdata : alu;
        if (bc == 3'd1) return src;
        if (bc == 3'd2) return src % 16'd256;
        if (bc == 3'd3) return src / 16'd256;
        if (bc == 3'd4) return addr;
        return alu;
    endfunction

    task automatic check_outputs(input string ctx);
        check_value({ctx, ".rf_wr_en_1"}, 32'(rf_wr_en_1), 32'(exp_en_1));
        check_value({ctx, ".rf_wr_en_2"}, 32'(rf_wr_en_2), 32'(exp_en_2));
        check_value({ctx, ".mem_req"},    32'(mem_req),    32'(exp_req));
        check_value({ctx, ".mem_err"},    32'(mem_err),    32'(exp_err));
        if (exp_req)
            check_value({ctx, ".mem_addr"}, 32'(mem_addr), 32'(exp_addr));
        if (exp_wb_known) begin
            check_value({ctx, ".rf_wr_sel"},  32'(rf_wr_sel),  32'(exp_sel));
            check_value({ctx, ".rf_wr_data"}, 32'(rf_wr_data), 32'(exp_data));
        end
    endtask

    // Runs one instruction to completion. ack_at is the WAIT-cycle index
    // (0-based) carrying mem_ack. A value of TO or more means no ack arrives.
    task automatic do_instr(input bit rd, input bit en1, input bit en2, input logic [2:0] bc,
                            input logic [3:0] sel, input logic [15:0] addr, input logic [15:0] alu,
                            input int ack_at, input logic [15:0] rdata);
        bit acked;
        mem_read_in    = rd;
        reg_wr_en_1_in = en1;
        reg_wr_en_2_in = en2;
        buff_ctrl_in   = bc;
        reg_wr_sel_in  = sel;
        mem_addr_in    = addr;
        alu_result_in  = alu;
        mem_ack        = rd ? 1'b0 : 1'($urandom_range(0, 1));
        mem_rdata      = 16'($urandom);
        @(negedge clk);
        check_value("idle.stall", 32'(stall), 32'(rd));
        check_outputs("idle");
        @(posedge clk);
        #1;
        if (!rd) begin
            exp_en_1 = en1; exp_en_2 = en2; exp_sel = sel;
            exp_data = expected_value(bc, 1'b0, 16'd0, alu, addr);
            exp_wb_known = 1'b1; exp_req = 1'b0; exp_err = 1'b0;
            mem_ack = 1'b0;
            $display("instr nonload sel=%0d bc=%0d en=%0b%0b data=%h", sel, bc, en1, en2, exp_data);
        end else begin
            exp_en_1 = 1'b0; exp_en_2 = 1'b0; exp_wb_known = 1'b0;
            exp_req = 1'b1; exp_addr = addr; exp_err = 1'b0;
            acked = 1'b0;
            for (int k = 0; k < TO; k++) begin
                mem_ack   = (k == ack_at);
                mem_rdata = (k == ack_at) ? rdata : 16'($urandom);
                @(negedge clk);
                check_value("wait.stall", 32'(stall), 32'd1);
                check_outputs("wait");
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
                if (k == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
            exp_req = 1'b0;
            if (acked) begin
                exp_en_1 = en1; exp_en_2 = en2; exp_sel = sel;
                exp_data = expected_value(bc, 1'b1, rdata, alu, addr);
                exp_wb_known = 1'b1; exp_err = 1'b0;
            end else begin
                exp_err = 1'b1;
            end
            // WB cycle: the instruction is retired, so the inputs are junk.
            mem_read_in    = 1'($urandom_range(0, 1));
            reg_wr_en_1_in = 1'($urandom_range(0, 1));
            reg_wr_en_2_in = 1'($urandom_range(0, 1));
            buff_ctrl_in   = 3'($urandom);
            reg_wr_sel_in  = 4'($urandom);
            mem_addr_in    = 16'($urandom);
            alu_result_in  = 16'($urandom);
            mem_ack        = 1'($urandom_range(0, 1));
            mem_rdata      = 16'($urandom);
            @(negedge clk);
            check_value("wb.stall", 32'(stall), 32'd0);
            check_outputs("wb");
            $display("instr load addr=%h bc=%0d ack_at=%0d %s data=%h", addr, bc, ack_at,
                     acked ? "acked" : "timeout", exp_data);
            @(posedge clk);
            #1;
            exp_en_1 = 1'b0; exp_en_2 = 1'b0; exp_err = 1'b0; exp_wb_known = 1'b0;
            mem_ack = 1'b0;
        end
    endtask

    task automatic expect_reset_state();
        exp_en_1 = 1'b0; exp_en_2 = 1'b0; exp_req = 1'b0; exp_err = 1'b0;
        exp_sel = 4'd0; exp_data = 16'd0; exp_addr = 16'd0; exp_wb_known = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        mem_read_in = 1'b0; reg_wr_en_1_in = 1'b0; reg_wr_en_2_in = 1'b0;
        buff_ctrl_in = 3'd0; reg_wr_sel_in = 4'd0; mem_addr_in = 16'd0;
        alu_result_in = 16'd0; mem_ack = 1'b0; mem_rdata = 16'd0;
        expect_reset_state();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_outputs("reset");
        check_value("reset.mem_addr", 32'(mem_addr), 32'd0);
        check_value("reset.stall0", 32'(stall), 32'd0);
        mem_read_in = 1'b1;
        #1;
        check_value("reset.stall1", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed cases.
        do_instr(1'b0, 1'b1, 1'b0, 3'b000, 4'd5, 16'h0000, 16'h1234, 0, 16'h0);
        do_instr(1'b1, 1'b1, 1'b0, 3'b001, 4'd3, 16'h0040, 16'h7777, 2, 16'hBEEF);
        do_instr(1'b1, 1'b1, 1'b1, 3'b010, 4'd7, 16'h0100, 16'h1111, 0, 16'hA5C3);
        do_instr(1'b1, 1'b0, 1'b1, 3'b011, 4'd8, 16'h0102, 16'h2222, 5, 16'hA5C3);
        do_instr(1'b1, 1'b1, 1'b1, 3'b001, 4'd9, 16'h0200, 16'h3333, 99, 16'h0);
        do_instr(1'b0, 1'b1, 1'b1, 3'b100, 4'd10, 16'hCAFE, 16'h4444, 0, 16'h0);
        do_instr(1'b1, 1'b1, 1'b0, 3'b001, 4'd11, 16'h0300, 16'h5555, TO - 1, 16'h1357);
        do_instr(1'b0, 1'b1, 1'b0, 3'b011, 4'd12, 16'h0000, 16'hA5C3, 0, 16'h0);
        do_instr(1'b0, 1'b0, 1'b0, 3'b110, 4'd13, 16'h0000, 16'h9876, 0, 16'h0);

        // Reset during the second WAIT cycle, then a late ack.
        mem_read_in = 1'b1; reg_wr_en_1_in = 1'b1; reg_wr_en_2_in = 1'b1;
        buff_ctrl_in = 3'b001; reg_wr_sel_in = 4'd4; mem_addr_in = 16'h0ABC;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_read_in = 1'b0; reg_wr_en_1_in = 1'b0; reg_wr_en_2_in = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        expect_reset_state();
        @(negedge clk);
        check_outputs("midwait_reset");
        check_value("midwait_reset.mem_addr", 32'(mem_addr), 32'd0);
        check_value("midwait_reset.stall", 32'(stall), 32'd0);
        $display("instr reset during WAIT cycle 2");
        @(posedge clk); #1;
        mem_ack = 1'b0;
        exp_sel = 4'd4; exp_data = 16'h0000;
        exp_wb_known = 1'b0;

        // Randomized instruction stream.
        for (int i = 0; i < 120; i++) begin
            do_instr(($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     3'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                     int'($urandom_range(0, TO + 2)), 16'($urandom));
        end
        do_instr(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 16'd0, 16'd0, 0, 16'd0);
        @(negedge clk);
        check_outputs("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
